instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Program-buffer sequencer that feeds the `cpu` block's 32-bit `current_instruction` input, one instruction per clock. A short program is loaded over a valid/ready port and executed on `start_in`. The sequencer stalls issue after every tensor-core operate instruction until the tensor core reports completion. It sits between the host/test harness and `cpu`, and replaces hand-driven instruction streams.

## Interface
- `DEPTH`, 16: program buffer capacity in 32-bit words (power of two, ≥2).
- `ADDR_WIDTH`, `$clog2(DEPTH)`: pointer width. Count width is `ADDR_WIDTH+1`.
- `TIMEOUT_CYCLES`, 64: WAIT_TC watchdog limit. Used only with `SEQUENCER_TIMEOUT_EN`.

Ports:
- `clock_in` in 1: single clock, rising edge.
- `reset_in` in 1: synchronous, active-low reset.
- `clear_in` in 1: synchronous flush of the program and state.
- `load_valid_in` in 1: program word valid.
- `load_data_in` in 32: program word, in cpu instruction format.
- `load_ready_out` out 1: buffer accepts a word.
- `start_in` in 1: run program from word 0.
- `tensor_core_done_in` in 1: tensor core finished its calculation.
- `current_instruction_out` out 32: registered instruction to `cpu`.
- `pc_out` out ADDR_WIDTH+1: index of the next word to issue.
- `busy_out` out 1: state is RUN or WAIT_TC.
- `halted_out` out 1: state is DONE.
- `timeout_out` out 1: sticky watchdog flag.

## Operation
- States: IDLE, RUN, WAIT_TC, DONE. Reset and `clear_in` enter IDLE with count=0, pc=0, output=NOP (32'h0000_0008), `timeout_out`=0.
- Priority: reset > clear > start > load.
- IDLE load: `load_ready_out` = (state==IDLE && count<DEPTH).
  - On a handshake, write `mem[count]` and increment count.
  - When count==DEPTH, ready=0 and further words are not taken.
- IDLE start: `start_in` is honoured only when count>0 and no load handshake happens in the same cycle. Otherwise it is ignored.
  - On start: output ← mem[0], pc ← 1, state ← RUN.
- RUN, evaluated each edge, in priority order:
  - If output[7:0]==8'h05 (TENSOR_CORE_OPERATE): output ← NOP, state ← WAIT_TC, pc unchanged, wait counter ← 0.
  - Else if pc==count: output ← NOP, state ← DONE.
  - Else: output ← mem[pc], pc ← pc+1.
- WAIT_TC:
  - Output holds NOP.
  - When `tensor_core_done_in`=1, perform the RUN issue step: issue mem[pc], or go to DONE if pc==count.
  - `tensor_core_done_in` is ignored in every other state, including the cycle in which OPERATE is on the output.
- DONE:
  - Output is NOP.
  - `start_in` re-executes the same program exactly as from IDLE and clears `timeout_out`.
  - Loads are not accepted; `clear_in` is required to load a new program.
- `start_in` in RUN or WAIT_TC is ignored.
- Buffer contents survive DONE and restart. Clear only zeroes count; memory contents are don't-care.
- The sequencer does not interpret RESET_OPCODE (8'h0D). It issues it like any other word.

## Timing
- All outputs are registered.
- Reset values: `current_instruction_out`=32'h0000_0008, `pc_out`=0, `busy_out`=0, `halted_out`=0, `timeout_out`=0, `load_ready_out`=1.
- Start sampled at edge E0: mem[0] is visible after E0, mem[k] after E(k), and NOP with `halted_out`=1 after E(count). There are no bubbles without OPERATE.
- OPERATE issued after edge En:
  - NOP from En+1.
  - With done sampled at edge Em (m≥n+2), the next word is visible after Em.
  - Minimum OPERATE-to-next-instruction gap is one NOP cycle.
- A load handshake takes effect in one cycle: with count=c before the edge, count=c+1 after it.

## Configuration
- `SEQUENCER_TIMEOUT_EN` defined:
  - The WAIT_TC counter increments each WAIT_TC cycle.
  - Reaching TIMEOUT_CYCLES−1 without done resumes issue exactly as if done had arrived, and sets `timeout_out`.
  - `timeout_out` stays set until clear, reset or start.
- `SEQUENCER_TIMEOUT_EN` undefined:
  - No counter; WAIT_TC waits indefinitely.
  - `timeout_out` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (NOP 8'h08, TENSOR_CORE_OPERATE 8'h05, and the rest of the opcode set);
  - `INSTRUCTION_WIDTH`=32;
  - the NOP instruction word;
  - the sequencer state enum.
- One sub-module, `instruction_buffer`: DEPTH×32 storage with a synchronous write port and an asynchronous read port, no reset on contents.

## Test plan
- Load 3 words (ADD 32'h0201_0000, SUB, MUL), then start: output ADD, SUB, MUL on consecutive cycles, then 32'h0000_0008. `halted_out`=1 three edges after start; `pc_out`=3.
- Program [ADD, OPERATE 32'h0000_0005, SUB]:
  - Done held 0 for 10 cycles: output NOP throughout and `busy_out`=1.
  - Done pulsed: SUB visible the next cycle.
  - Done asserted during the OPERATE cycle is ignored.
- Load with `load_valid_in` stuck high: exactly DEPTH=16 words accepted, `load_ready_out`=0 after the 16th. Start with count=0 is ignored; state stays IDLE.
- With `SEQUENCER_TIMEOUT_EN`, TIMEOUT_CYCLES=8, OPERATE issued and done never asserted: issue resumes after the 8th WAIT_TC cycle with `timeout_out`=1. Restart clears it.
- `clear_in` mid-RUN: next cycle IDLE, output NOP, `pc_out`=0, `load_ready_out`=1. `reset_in`=0 mid-WAIT_TC gives all outputs at their reset values.
- From DONE, start re-runs the identical instruction sequence. `load_valid_in` in DONE is not accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared cpu definitions: instruction width, opcode constants, the NOP
// instruction word and the instruction sequencer state encoding.
package cpu_pkg;

    localparam int INSTRUCTION_WIDTH = 32;

    // Opcodes live in instruction bits [7:0].
    localparam logic [7:0] OP_ADD                 = 8'h00;
    localparam logic [7:0] OP_SUB                 = 8'h01;
    localparam logic [7:0] OP_MUL                 = 8'h02;
    localparam logic [7:0] OP_LOAD                = 8'h03;
    localparam logic [7:0] OP_STORE               = 8'h04;
    localparam logic [7:0] OP_TENSOR_CORE_OPERATE = 8'h05;
    localparam logic [7:0] OP_TENSOR_CORE_LOAD    = 8'h06;
    localparam logic [7:0] OP_TENSOR_CORE_STORE   = 8'h07;
    localparam logic [7:0] OP_NOP                 = 8'h08;
    localparam logic [7:0] OP_RESET               = 8'h0D;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0008;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_RUN     = 2'd1,
        SEQ_WAIT_TC = 2'd2,
        SEQ_DONE    = 2'd3
    } seq_state_t;

    // True when the word asks the tensor core to run a calculation.
    function automatic logic is_tensor_operate(input logic [INSTRUCTION_WIDTH-1:0] instr);
        return instr[7:0] == OP_TENSOR_CORE_OPERATE;
    endfunction

endpackage

// File: rtl/instruction_buffer.sv
// Program storage for the instruction sequencer: DEPTH x 32-bit words,
// synchronous write, asynchronous read, contents are not reset.
module instruction_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clock_in,
    input  logic                         write_enable,
    input  logic [ADDR_WIDTH-1:0]        write_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0]        read_addr,
    output logic [INSTRUCTION_WIDTH-1:0] read_data
);

    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];

    // Write one program word per accepted load.
    always_ff @(posedge clock_in) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// Program-buffer sequencer feeding the cpu one instruction per clock.
// A program is loaded in IDLE, run on start_in, and issue stalls after each
// tensor-core operate until tensor_core_done_in.
// Optional feature macro: SEQUENCER_TIMEOUT_EN enables the WAIT_TC watchdog.
//
// Load handshake: a word transfers on a rising edge where load_valid_in and
// load_ready_out are both 1; load_data_in must be stable while valid is high,
// and ready depends only on registered state, never on valid.
module instruction_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  clear_in,
    input  logic                  load_valid_in,
    input  logic [31:0]           load_data_in,
    output logic                  load_ready_out,
    input  logic                  start_in,
    input  logic                  tensor_core_done_in,
    output logic [31:0]           current_instruction_out,
    output logic [ADDR_WIDTH:0]   pc_out,
    output logic                  busy_out,
    output logic                  halted_out,
    output logic                  timeout_out,
    output logic [1:0]            state_out
);

    seq_state_t                   state_q, state_d;
    logic [ADDR_WIDTH:0]          count_q, count_d;
    logic [ADDR_WIDTH:0]          pc_q, pc_d;
    logic [31:0]                  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [31:0]                  rd_data;
    logic                         load_fire;
    logic                         start_fire;
    logic                         tc_expired;

    // count<DEPTH is simply the count MSB being clear, as DEPTH is a power of two.
    assign load_ready_out = (state_q == SEQ_IDLE) && !count_q[ADDR_WIDTH];
    assign load_fire      = load_valid_in && load_ready_out;
    assign start_fire     = start_in &&
                            (((state_q == SEQ_IDLE) && (count_q != '0) && !load_fire) ||
                             (state_q == SEQ_DONE));

    // A start always fetches word 0; otherwise the read port follows pc.
    assign rd_addr = (state_q == SEQ_IDLE || state_q == SEQ_DONE) ? '0 : pc_q[ADDR_WIDTH-1:0];

    instruction_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clock_in     (clock_in),
        .write_enable (load_fire && !clear_in),
        .write_addr   (count_q[ADDR_WIDTH-1:0]),
        .write_data   (load_data_in),
        .read_addr    (rd_addr),
        .read_data    (rd_data)
    );

    // Next-state logic: clear beats start, start beats load; issue steps in RUN/WAIT_TC.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_in) begin
            state_d = SEQ_IDLE;
            count_d = '0;
            pc_d    = '0;
            instr_d = NOP_INSTRUCTION;
        end else begin
            case (state_q)
                SEQ_IDLE, SEQ_DONE: begin
                    if (start_fire) begin
                        instr_d = rd_data;
                        pc_d    = {{ADDR_WIDTH{1'b0}}, 1'b1};
                        state_d = SEQ_RUN;
                    end else if (load_fire) begin
                        count_d = count_q + 1'b1;
                    end
                end
                SEQ_RUN, SEQ_WAIT_TC: begin
                    if (state_q == SEQ_RUN && is_tensor_operate(instr_q)) begin
                        instr_d = NOP_INSTRUCTION;
                        state_d = SEQ_WAIT_TC;
                    end else if (state_q == SEQ_RUN || tensor_core_done_in || tc_expired) begin
                        if (pc_q == count_q) begin
                            instr_d = NOP_INSTRUCTION;
                            state_d = SEQ_DONE;
                        end else begin
                            instr_d = rd_data;
                            pc_d    = pc_q + 1'b1;
                            state_d = SEQ_RUN;
                        end
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q <= SEQ_IDLE;
            count_q <= '0;
            pc_q    <= '0;
            instr_q <= NOP_INSTRUCTION;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef SEQUENCER_TIMEOUT_EN
    localparam int WAIT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  timeout_q, timeout_d;

    assign tc_expired = (state_q == SEQ_WAIT_TC) &&
                        (wait_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Watchdog: count stalled WAIT_TC cycles, latch a sticky flag on expiry.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (!clear_in && state_q == SEQ_WAIT_TC && !tensor_core_done_in && !tc_expired) begin
            wait_d = wait_q + 1'b1;
        end
        if (clear_in || start_fire) begin
            timeout_d = 1'b0;
        end else if (tc_expired && !tensor_core_done_in) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign tc_expired         = 1'b0;
    assign timeout_out        = 1'b0;
`endif

    assign current_instruction_out = instr_q;
    assign pc_out                  = pc_q;
    assign busy_out                = (state_q == SEQ_RUN) || (state_q == SEQ_WAIT_TC);
    assign halted_out              = (state_q == SEQ_DONE);
    assign state_out               = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed stimulus pushes the
// expected post-edge output snapshot, a negedge monitor pops and compares.
module tb_instruction_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0008;
    localparam logic [31:0] ADD = 32'h0201_0000;
    localparam logic [31:0] SUB = 32'h0201_0001;
    localparam logic [31:0] MUL = 32'h0201_0002;
    localparam logic [31:0] OPR = 32'h0000_0005;

`ifdef SEQUENCER_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 10;
`endif

    localparam int W = 43;

    // clock / reset / dut
    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        load_valid_in = 1'b0;
    logic [31:0] load_data_in = '0;
    logic        start_in = 1'b0;
    logic        done_in = 1'b0;
    logic        load_ready_out;
    logic [31:0] current_instruction_out;
    logic [4:0]  pc_out;
    logic        busy_out, halted_out, timeout_out;
    logic [1:0]  state_out;

    always #5 clk = ~clk;

    instruction_sequencer #(
        .DEPTH          (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock_in                (clk),
        .reset_in                (reset_in),
        .clear_in                (clear_in),
        .load_valid_in           (load_valid_in),
        .load_data_in            (load_data_in),
        .load_ready_out          (load_ready_out),
        .start_in                (start_in),
        .tensor_core_done_in     (done_in),
        .current_instruction_out (current_instruction_out),
        .pc_out                  (pc_out),
        .busy_out                (busy_out),
        .halted_out              (halted_out),
        .timeout_out             (timeout_out),
        .state_out               (state_out)
    );

    // scoreboard
    typedef struct {
        int          cyc;
        string       tag;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   tests   = 0;
    int   fails   = 0;
    exp_t mon_e;
    logic [W-1:0] act;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign act = {current_instruction_out, pc_out, busy_out, halted_out,
                  timeout_out, load_ready_out, state_out};

    // monitor: compare every expectation that belongs to the edge just passed
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            mon_e = exp_q.pop_front();
            tests = tests + 1;
            if (mon_e.cyc != cyc_cnt || act !== mon_e.val) begin
                fails = fails + 1;
                $display("FAIL %s cyc=%0d got=%h exp=%h (instr,pc,busy,halt,tmo,rdy,st)",
                         mon_e.tag, mon_e.cyc, act, mon_e.val);
            end
        end
    end

    // driver: inputs are already set; record the expected result of the next edge
    task automatic tick(input string tag, input logic [1:0] st, input logic [31:0] ins,
                        input logic [4:0] pc, input logic rdy, input logic tmo);
        exp_t e;
        e.cyc = cyc_cnt + 1;
        e.tag = tag;
        e.val = {ins, pc, (st == S_RUN || st == S_WAIT), (st == S_DONE), tmo, rdy, st};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        load_valid_in = 1'b1;
        load_data_in = a; tick("load_w0", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        load_data_in = b; tick("load_w1", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        load_data_in = c; tick("load_w2", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        load_valid_in = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'h1000_0001 | (32'(i) << 8);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        tick("reset", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        tick("reset", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        reset_in = 1'b1;

        // start with empty buffer is ignored
        start_in = 1'b1;
        tick("start_empty", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);

        // valid stuck high: 16 words taken; start with a handshake is ignored
        for (int i = 0; i < 18; i++) begin
            load_valid_in = 1'b1;
            load_data_in  = word(i);
            start_in      = (i == 0);
            tick("full_load", S_IDLE, NOP, 5'd0, (i < 15), 1'b0);
        end
        load_valid_in = 1'b0;
        start_in = 1'b1;
        tick("full_run", S_RUN, word(0), 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick("full_run", S_RUN, word(k), 5'(k + 1), 1'b0, 1'b0);
        end
        tick("full_done", S_DONE, NOP, 5'd16, 1'b0, 1'b0);

        // restart then clear mid-run
        start_in = 1'b1;
        tick("rerun16", S_RUN, word(0), 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("rerun16", S_RUN, word(1), 5'd2, 1'b0, 1'b0);
        clear_in = 1'b1;
        tick("clear_run", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        clear_in = 1'b0;

        // basic three-word program
        load3(ADD, SUB, MUL);
        start_in = 1'b1;
        tick("basic_add", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("basic_sub", S_RUN, SUB, 5'd2, 1'b0, 1'b0);
        tick("basic_mul", S_RUN, MUL, 5'd3, 1'b0, 1'b0);
        tick("basic_halt", S_DONE, NOP, 5'd3, 1'b0, 1'b0);
        load_valid_in = 1'b1;
        load_data_in  = OPR;
        tick("done_load", S_DONE, NOP, 5'd3, 1'b0, 1'b0);
        load_valid_in = 1'b0;
        start_in = 1'b1;
        tick("rerun_add", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("rerun_sub", S_RUN, SUB, 5'd2, 1'b0, 1'b0);
        tick("rerun_mul", S_RUN, MUL, 5'd3, 1'b0, 1'b0);
        tick("rerun_halt", S_DONE, NOP, 5'd3, 1'b0, 1'b0);

        // operate stall
        clear_in = 1'b1;
        tick("clear_done", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        clear_in = 1'b0;
        load3(ADD, OPR, SUB);
        start_in = 1'b1;
        tick("tc_add", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("tc_opr", S_RUN, OPR, 5'd2, 1'b0, 1'b0);
        done_in = 1'b1;
        tick("tc_done_ignored", S_WAIT, NOP, 5'd2, 1'b0, 1'b0);
        done_in = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            start_in = (i == 2);
            tick("tc_hold", S_WAIT, NOP, 5'd2, 1'b0, 1'b0);
        end
        start_in = 1'b0;
        done_in = 1'b1;
        tick("tc_resume", S_RUN, SUB, 5'd3, 1'b0, 1'b0);
        done_in = 1'b0;
        tick("tc_halt", S_DONE, NOP, 5'd3, 1'b0, 1'b0);

        // reset while waiting on the tensor core
        start_in = 1'b1;
        tick("rst_add", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("rst_opr", S_RUN, OPR, 5'd2, 1'b0, 1'b0);
        tick("rst_wait", S_WAIT, NOP, 5'd2, 1'b0, 1'b0);
        reset_in = 1'b0;
        tick("rst_midwait", S_IDLE, NOP, 5'd0, 1'b1, 1'b0);
        reset_in = 1'b1;

`ifdef SEQUENCER_TIMEOUT_EN
        // watchdog: 8 WAIT_TC cycles without done
        load3(ADD, OPR, SUB);
        start_in = 1'b1;
        tick("to_add", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("to_opr", S_RUN, OPR, 5'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick("to_wait", S_WAIT, NOP, 5'd2, 1'b0, 1'b0);
        end
        tick("to_resume", S_RUN, SUB, 5'd3, 1'b0, 1'b1);
        tick("to_halt", S_DONE, NOP, 5'd3, 1'b0, 1'b1);
        start_in = 1'b1;
        tick("to_restart", S_RUN, ADD, 5'd1, 1'b0, 1'b0);
        start_in = 1'b0;
        tick("to_opr2", S_RUN, OPR, 5'd2, 1'b0, 1'b0);
        tick("to_wait2", S_WAIT, NOP, 5'd2, 1'b0, 1'b0);
        done_in = 1'b1;
        tick("to_done_path", S_RUN, SUB, 5'd3, 1'b0, 1'b0);
        done_in = 1'b0;
        tick("to_halt2", S_DONE, NOP, 5'd3, 1'b0, 1'b0);
`endif

        // report
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL unchecked_expectations got=%0d exp=0", exp_q.size());
            tests = tests + 1;
            fails = fails + 1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
